// File: rtl/riscv_muldiv_pkg.sv
// riscv_muldiv_pkg: RV32M op encodings, FSM states and operand-signedness helpers
package riscv_muldiv_pkg;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction
  function automatic logic is_signed_a(input logic [2:0] op);
    return op[2] ? ~op[0] : (op[1:0] != 2'b11);
  endfunction
  function automatic logic is_signed_b(input logic [2:0] op);
    return op[2] ? ~op[0] : ~op[1];
  endfunction
endpackage

// File: rtl/riscv_muldiv_step.sv
// riscv_muldiv_step: one combinational shift-add (multiply) or trial-subtract (divide) iteration
//   div_i  1       select restoring-divide step instead of shift-add
//   p_i    2*XLEN  working register in: {acc, multiplier} or {remainder, dividend/quotient}
//   m_i    XLEN    multiplicand magnitude or divisor magnitude
//   p_o    2*XLEN  working register after one iteration
module riscv_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              div_i,
  input  logic [2*XLEN-1:0] p_i,
  input  logic [XLEN-1:0]   m_i,
  output logic [2*XLEN-1:0] p_o
);
  logic [XLEN:0]   sum;
  logic [XLEN:0]   sh;
  logic [XLEN-1:0] dif;
  logic [XLEN-1:0] up;
  logic            ge;
  // Multiply: add multiplicand when the multiplier LSB is set, carry shifts into the top
  assign sum = {1'b0, p_i[2*XLEN-1:XLEN]} + {1'b0, (p_i[0] ? m_i : {XLEN{1'b0}})};
  // Divide: remainder shifted left with the next dividend bit needs XLEN+1 bits to compare
  assign sh  = p_i[2*XLEN-1:XLEN-1];
  assign ge  = sh >= {1'b0, m_i};
  // Difference is below the divisor whenever it is used, so XLEN-bit modular subtract suffices
  assign dif = sh[XLEN-1:0] - m_i;
  assign up  = ge ? dif : sh[XLEN-1:0];
  assign p_o = div_i ? {up, p_i[XLEN-2:0], ge} : {sum, p_i[XLEN-1:1]};
endmodule

// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: iterative RV32M multiply/divide unit with valid/ready handshake and flush
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid_i/in_ready_o      request handshake (ready only when idle)
//   op_i, a_i, b_i             funct3 op and rs1/rs2 operands, latched at accept
//   flush_i                    kills any op in flight, wins over accept and output handshake
//   out_valid_o/out_ready_i    result handshake; result_o held until taken
//   busy_o                     unit not idle
module riscv_muldiv_unit
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);
  localparam int N  = XLEN / STEPS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] p_q, prod;
  logic [XLEN-1:0]   m_q;
  logic [2:0]        op_q;
  logic              neg_q, neg_r_q;
  logic              accept, sa, sb, b_zero, ovf, special, last, op_div;
  logic [XLEN-1:0]   abs_a, abs_b, special_res, quo, rem, fix_res;
  logic [2*XLEN-1:0] chain [STEPS_PER_CYCLE+1];
  assign in_ready_o = state_q == S_IDLE;
  assign busy_o     = state_q != S_IDLE;
  assign accept     = in_valid_i & in_ready_o & ~flush_i;
  assign sa         = is_signed_a(op_i) & a_i[XLEN-1];
  assign sb         = is_signed_b(op_i) & b_i[XLEN-1];
  assign abs_a      = sa ? -a_i : a_i;
  assign abs_b      = sb ? -b_i : b_i;
  // Division cases resolved at accept without iterating
  assign b_zero      = is_div(op_i) & (b_i == '0);
  assign ovf         = is_div(op_i) & ~op_i[0] & (a_i == MOST_NEG) & (b_i == '1);
  assign special     = b_zero | ovf;
  assign special_res = b_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);
  assign op_div   = is_div(op_q);
  assign chain[0] = p_q;
  for (genvar s = 0; s < STEPS_PER_CYCLE; s++) begin : g_step
    riscv_muldiv_step #(.XLEN(XLEN)) u_step (
      .div_i(op_div),
      .p_i  (chain[s]),
      .m_i  (m_q),
      .p_o  (chain[s+1])
    );
  end
  // Sign fix: product/quotient follow sa^sb, remainder follows the dividend
  assign prod    = neg_q ? -p_q : p_q;
  assign quo     = neg_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
  assign rem     = neg_r_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
  assign fix_res = op_div ? (op_q[1] ? rem : quo) :
                   (op_q == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  assign last    = cnt_q == CW'(N - 1);
  always_comb begin
    state_d = flush_i              ? S_IDLE :
              state_q == S_IDLE    ? (accept ? (special ? S_DONE : S_CALC) : S_IDLE) :
              state_q == S_CALC    ? (last ? S_FIX : S_CALC) :
              state_q == S_FIX     ? S_DONE :
              (out_valid_o & out_ready_i) ? S_IDLE : S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      p_q         <= '0;
      m_q         <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      neg_r_q     <= 1'b0;
      result_o    <= '0;
      out_valid_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_o <= state_d == S_DONE;
      if (accept) begin
        op_q    <= op_i;
        neg_q   <= sa ^ sb;
        neg_r_q <= sa;
        cnt_q   <= '0;
        p_q     <= {{XLEN{1'b0}}, (is_div(op_i) ? abs_a : abs_b)};
        m_q     <= is_div(op_i) ? abs_b : abs_a;
        if (special) result_o <= special_res;
      end
      if (state_q == S_CALC) begin
        p_q   <= chain[STEPS_PER_CYCLE];
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == S_FIX) result_o <= fix_res;
    end
  end
endmodule
